// File: rtl/gemm_sram_engine_if.sv
// SRAM-side bus of the GEMM engine: A/B read ports and the C write port.
// The engine drives the master modport; the memories sit on the slave modport.
interface gemm_sram_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] a_rd_addr;
  logic [DATA_W-1:0] a_rd_data;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [DATA_W-1:0] b_rd_data;
  logic              c_wr_en;
  logic [ADDR_W-1:0] c_wr_addr;
  logic [DATA_W-1:0] c_wr_data;

  modport master (
    output a_rd_addr, input a_rd_data,
    output b_rd_addr, input b_rd_data,
    output c_wr_en, output c_wr_addr, output c_wr_data
  );

  modport slave (
    input a_rd_addr, output a_rd_data,
    input b_rd_addr, output b_rd_data,
    input c_wr_en, input c_wr_addr, input c_wr_data
  );
endinterface

// File: rtl/gemm_sram_engine.sv
// Configurable C = A x B / A x B^T engine streaming operands from SRAM,
// one MAC per cycle, writing C row-major with no bubbles between elements.
module gemm_sram_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  input  logic [DIM_W-1:0]  i_cfg_m,
  input  logic [DIM_W-1:0]  i_cfg_k,
  input  logic [DIM_W-1:0]  i_cfg_n,
  input  logic [ADDR_W-1:0] i_cfg_a_base,
  input  logic [ADDR_W-1:0] i_cfg_b_base,
  input  logic [ADDR_W-1:0] i_cfg_c_base,
  input  logic              i_cfg_transpose_b,
  gemm_sram_engine_if.master io_mem
);
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [DIM_W-1:0]  r_m, r_k, r_n;
  logic [DIM_W-1:0]  r_i, r_j, r_kk;
  logic              r_tb;
  logic [ADDR_W-1:0] r_a_addr, r_a_row;
  logic [ADDR_W-1:0] r_b_addr, r_b_col, r_b_base;
  logic [ADDR_W-1:0] r_c_next;
  logic              r_drain;
  logic              r_d_vld, r_d_first, r_d_last;
  logic [DATA_W-1:0] r_acc;
  logic              r_c_wr_en;
  logic [ADDR_W-1:0] r_c_wr_addr;
  logic [DATA_W-1:0] r_c_wr_data;
  logic              r_busy, r_done;

  logic [PROD_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [DATA_W-1:0] w_sum;
  logic              w_k_last, w_j_last, w_i_last, w_zero_dim, w_abort;
  logic              w_unused_prod_hi;

  // Operand extension selects signed vs unsigned full-width products
  if (SIGNED != 0) begin : g_signed
    assign w_a_ext = PROD_W'($signed(io_mem.a_rd_data));
    assign w_b_ext = PROD_W'($signed(io_mem.b_rd_data));
  end else begin : g_unsigned
    assign w_a_ext = PROD_W'(io_mem.a_rd_data);
    assign w_b_ext = PROD_W'(io_mem.b_rd_data);
  end

  assign w_prod           = w_a_ext * w_b_ext;
  assign w_unused_prod_hi = ^w_prod[PROD_W-1:DATA_W];
  assign w_sum      = r_d_first ? w_prod[DATA_W-1:0] : r_acc + w_prod[DATA_W-1:0];
  assign w_k_last   = (r_kk == r_k - DIM_W'(1));
  assign w_j_last   = (r_j == r_n - DIM_W'(1));
  assign w_i_last   = (r_i == r_m - DIM_W'(1));
  assign w_zero_dim = (i_cfg_m == '0) || (i_cfg_k == '0) || (i_cfg_n == '0);
  assign w_abort    = i_abort && (r_state != S_IDLE);

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign io_mem.a_rd_addr = r_a_addr;
  assign io_mem.b_rd_addr = r_b_addr;
  // Abort must suppress a write already sitting in the output register
  assign io_mem.c_wr_en   = r_c_wr_en & ~w_abort;
  assign io_mem.c_wr_addr = r_c_wr_addr;
  assign io_mem.c_wr_data = r_c_wr_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_kk        <= '0;
      r_tb        <= 1'b0;
      r_a_addr    <= '0;
      r_a_row     <= '0;
      r_b_addr    <= '0;
      r_b_col     <= '0;
      r_b_base    <= '0;
      r_c_next    <= '0;
      r_drain     <= 1'b0;
      r_d_vld     <= 1'b0;
      r_d_first   <= 1'b0;
      r_d_last    <= 1'b0;
      r_acc       <= '0;
      r_c_wr_en   <= 1'b0;
      r_c_wr_addr <= '0;
      r_c_wr_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_c_wr_en <= 1'b0;
      r_d_vld   <= 1'b0;

      // Data stage: read data returned this cycle is folded into the accumulator
      if (r_d_vld) begin
        r_acc <= w_sum;
        if (r_d_last) begin
          r_c_wr_en   <= 1'b1;
          r_c_wr_addr <= r_c_next;
          r_c_wr_data <= w_sum;
          r_c_next    <= r_c_next + ADDR_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m      <= i_cfg_m;
            r_k      <= i_cfg_k;
            r_n      <= i_cfg_n;
            r_tb     <= i_cfg_transpose_b;
            r_i      <= '0;
            r_j      <= '0;
            r_kk     <= '0;
            r_a_addr <= i_cfg_a_base;
            r_a_row  <= i_cfg_a_base;
            r_b_addr <= i_cfg_b_base;
            r_b_col  <= i_cfg_b_base;
            r_b_base <= i_cfg_b_base;
            r_c_next <= i_cfg_c_base;
            if (w_zero_dim) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_d_vld   <= 1'b1;
          r_d_first <= (r_kk == '0);
          r_d_last  <= w_k_last;
          if (w_k_last && w_j_last && w_i_last) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else if (!w_k_last) begin
            r_kk     <= r_kk + DIM_W'(1);
            r_a_addr <= r_a_addr + ADDR_W'(1);
            r_b_addr <= r_tb ? r_b_addr + ADDR_W'(1) : r_b_addr + ADDR_W'(r_n);
          end else if (!w_j_last) begin
            // Next column: rewind A to the row start, step B to the next column/row
            r_kk     <= '0;
            r_j      <= r_j + DIM_W'(1);
            r_a_addr <= r_a_row;
            r_b_addr <= r_tb ? r_b_addr + ADDR_W'(1) : r_b_col + ADDR_W'(1);
            r_b_col  <= r_b_col + ADDR_W'(1);
          end else begin
            r_kk     <= '0;
            r_j      <= '0;
            r_i      <= r_i + DIM_W'(1);
            r_a_addr <= r_a_addr + ADDR_W'(1);
            r_a_row  <= r_a_addr + ADDR_W'(1);
            r_b_addr <= r_b_base;
            r_b_col  <= r_b_base;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_d_vld   <= 1'b0;
        r_c_wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gemm_sram_engine.sv
// Directed bench for gemm_sram_engine: an unsigned and a signed instance share
// stimulus and memories and are checked every cycle against a matrix-level model.
module tb_gemm_sram_engine;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DIM_W  = 16;
  localparam int          NCYC   = 64;

  logic clk = 1'b0;
  logic reset_n, start, abort, cfg_tb;
  logic [DIM_W-1:0]  cfg_m, cfg_k, cfg_n;
  logic [ADDR_W-1:0] cfg_a, cfg_b, cfg_c;
  logic busy_u, done_u, busy_s, done_s;

  always #5 clk = ~clk;

  gemm_sram_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_u ();
  gemm_sram_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_s ();

  gemm_sram_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .SIGNED(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_abort(abort),
    .o_busy(busy_u), .o_done(done_u),
    .i_cfg_m(cfg_m), .i_cfg_k(cfg_k), .i_cfg_n(cfg_n),
    .i_cfg_a_base(cfg_a), .i_cfg_b_base(cfg_b), .i_cfg_c_base(cfg_c),
    .i_cfg_transpose_b(cfg_tb), .io_mem(if_u));

  gemm_sram_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .SIGNED(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_abort(abort),
    .o_busy(busy_s), .o_done(done_s),
    .i_cfg_m(cfg_m), .i_cfg_k(cfg_k), .i_cfg_n(cfg_n),
    .i_cfg_a_base(cfg_a), .i_cfg_b_base(cfg_b), .i_cfg_c_base(cfg_c),
    .i_cfg_transpose_b(cfg_tb), .io_mem(if_s));

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  // Synchronous-read SRAMs: data appears the cycle after the address
  always @(posedge clk) begin
    if_u.a_rd_data <= mem_a[if_u.a_rd_addr[7:0]];
    if_u.b_rd_data <= mem_b[if_u.b_rd_addr[7:0]];
    if_s.a_rd_data <= mem_a[if_s.a_rd_addr[7:0]];
    if_s.b_rd_data <= mem_b[if_s.b_rd_addr[7:0]];
  end

  logic        exp_busy  [NCYC];
  logic        exp_done  [NCYC];
  logic        exp_wen   [NCYC];
  logic [15:0] exp_waddr [NCYC];
  logic [31:0] exp_wdata [NCYC];
  logic        exp_achk  [NCYC];
  logic [15:0] exp_aaddr [NCYC];
  logic [15:0] exp_baddr [NCYC];

  int          n_vec = 0;
  int          n_err = 0;
  int          chk_cyc = 0;
  bit          chk_on = 1'b0;
  int          done_cyc = -1;
  logic [31:0] cap_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, chk_cyc, act, exp);
    end
  endtask

  // Expected per-cycle behaviour, derived from the loop nest and matrix product
  task automatic build_model(input int m, input int k, input int n, input int ab, input int bb,
                             input int cb, input bit tr, input int abort_at);
    int mnk, i, j, kk, c, ai, bi;
    logic [31:0] sum;
    for (int x = 0; x < NCYC; x++) begin
      exp_busy[x] = 1'b0; exp_done[x] = 1'b0; exp_wen[x] = 1'b0; exp_achk[x] = 1'b0;
      exp_waddr[x] = '0; exp_wdata[x] = '0; exp_aaddr[x] = '0; exp_baddr[x] = '0;
    end
    mnk = m * n * k;
    if (mnk == 0) begin
      exp_done[1] = 1'b1;
    end else begin
      for (int x = 1; x <= mnk + 2; x++) exp_busy[x] = 1'b1;
      exp_done[mnk + 3] = 1'b1;
      for (int r = 0; r < mnk; r++) begin
        i  = r / (n * k);
        j  = (r / k) % n;
        kk = r % k;
        exp_achk[r + 1]  = 1'b1;
        exp_aaddr[r + 1] = 16'(ab + i * k + kk);
        exp_baddr[r + 1] = tr ? 16'(bb + j * k + kk) : 16'(bb + kk * n + j);
      end
      for (int x = mnk + 1; x <= mnk + 2; x++) begin
        exp_achk[x]  = 1'b1;
        exp_aaddr[x] = exp_aaddr[mnk];
        exp_baddr[x] = exp_baddr[mnk];
      end
      for (int e = 0; e < m * n; e++) begin
        i = e / n;
        j = e % n;
        sum = '0;
        for (int q = 0; q < k; q++) begin
          ai = (ab + i * k + q) & 255;
          bi = (tr ? (bb + j * k + q) : (bb + q * n + j)) & 255;
          sum = sum + 32'(mem_a[ai] * mem_b[bi]);
        end
        c = (e + 1) * k + 2;
        exp_wen[c]   = 1'b1;
        exp_waddr[c] = 16'(cb + e);
        exp_wdata[c] = sum;
      end
      if (abort_at > 0) begin
        for (int x = abort_at; x < NCYC; x++) begin
          exp_wen[x] = 1'b0;
          if (x > abort_at) begin
            exp_busy[x] = 1'b0; exp_done[x] = 1'b0; exp_achk[x] = 1'b0;
          end
        end
      end
    end
  endtask

  // Single compare process, mid-cycle, against the model tables
  always @(negedge clk) begin
    if (chk_on) begin
      chk_cyc++;
      if (chk_cyc < NCYC) begin
        check("busy_u", busy_u, exp_busy[chk_cyc]);
        check("busy_s", busy_s, exp_busy[chk_cyc]);
        check("done_u", done_u, exp_done[chk_cyc]);
        check("done_s", done_s, exp_done[chk_cyc]);
        check("wen_u", if_u.c_wr_en, exp_wen[chk_cyc]);
        check("wen_s", if_s.c_wr_en, exp_wen[chk_cyc]);
        if (done_u) done_cyc = chk_cyc;
        if (exp_wen[chk_cyc]) begin
          check("waddr_u", if_u.c_wr_addr, exp_waddr[chk_cyc]);
          check("waddr_s", if_s.c_wr_addr, exp_waddr[chk_cyc]);
          check("wdata_u", if_u.c_wr_data, exp_wdata[chk_cyc]);
          check("wdata_s", if_s.c_wr_data, exp_wdata[chk_cyc]);
          cap_q.push_back(if_u.c_wr_data);
        end
        if (exp_achk[chk_cyc]) begin
          check("a_addr_u", if_u.a_rd_addr, exp_aaddr[chk_cyc]);
          check("b_addr_u", if_u.b_rd_addr, exp_baddr[chk_cyc]);
          check("a_addr_s", if_s.a_rd_addr, exp_aaddr[chk_cyc]);
          check("b_addr_s", if_s.b_rd_addr, exp_baddr[chk_cyc]);
        end
      end
    end
  end

  task automatic run_job(input int m, input int k, input int n, input int ab, input int bb,
                         input int cb, input bit tr, input int abort_at, input int restart_at);
    build_model(m, k, n, ab, bb, cb, tr, abort_at);
    cap_q.delete();
    done_cyc = -1;
    @(negedge clk);
    cfg_m = 16'(m); cfg_k = 16'(k); cfg_n = 16'(n);
    cfg_a = 16'(ab); cfg_b = 16'(bb); cfg_c = 16'(cb); cfg_tb = tr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_cyc = 0;
    chk_on = 1'b1;
    // Scramble config after acceptance; the running job must not see it
    cfg_m = 16'd7; cfg_k = 16'd0; cfg_n = 16'd5;
    cfg_a = 16'h00F0; cfg_b = 16'h00E0; cfg_c = 16'h00D0; cfg_tb = ~tr;
    for (int c = 1; c <= m * n * k + 6; c++) begin
      abort = (c == abort_at);
      start = (c == restart_at);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    start = 1'b0;
    chk_on = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_tb = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0;
    for (int x = 0; x < 256; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
    mem_b[16] = 32'd5; mem_b[17] = 32'd6; mem_b[18] = 32'd7; mem_b[19] = 32'd8;
    mem_a[64] = 32'd2; mem_a[65] = 32'd3; mem_a[66] = 32'd5;
    mem_b[80] = 32'd7; mem_b[81] = 32'd11; mem_b[82] = 32'd13; mem_b[83] = 32'd17;
    mem_a[128] = 32'hFFFF_FFFF; mem_b[144] = 32'd2;
    mem_a[129] = 32'hFFFF_FFFD; mem_b[145] = 32'd4;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {busy_u, busy_s}, 2'b00);
    check("rst_done", {done_u, done_s}, 2'b00);
    check("rst_wen", {if_u.c_wr_en, if_s.c_wr_en}, 2'b00);
    check("rst_a_addr", if_u.a_rd_addr, 16'h0);
    check("rst_b_addr", if_u.b_rd_addr, 16'h0);
    check("rst_c_addr", if_u.c_wr_addr, 16'h0);
    check("rst_c_data", if_u.c_wr_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 2x2x2, B row-major, with a start retry at cycle 3 that must be ignored
    run_job(2, 2, 2, 'h00, 'h10, 'h20, 1'b0, 0, 3);
    check("nn_count", cap_q.size(), 4);
    check("nn_c0", cap_q[0], 32'd19);
    check("nn_c1", cap_q[1], 32'd22);
    check("nn_c2", cap_q[2], 32'd43);
    check("nn_c3", cap_q[3], 32'd50);
    check("nn_done_cycle", done_cyc, 11);

    run_job(2, 2, 2, 'h00, 'h10, 'h20, 1'b1, 0, 0);
    check("nt_c0", cap_q[0], 32'd17);
    check("nt_c1", cap_q[1], 32'd23);
    check("nt_c2", cap_q[2], 32'd39);
    check("nt_c3", cap_q[3], 32'd53);

    run_job(3, 1, 4, 'h40, 'h50, 'h60, 1'b0, 0, 0);
    check("op_count", cap_q.size(), 12);
    check("op_c5", cap_q[5], 32'd33);
    check("op_c11", cap_q[11], 32'd85);
    check("op_done_cycle", done_cyc, 15);

    run_job(1, 1, 1, 'h80, 'h90, 'hA0, 1'b0, 0, 0);
    check("wrap_c0", cap_q[0], 32'hFFFF_FFFE);
    run_job(1, 1, 1, 'h81, 'h91, 'hA1, 1'b0, 0, 0);
    check("neg_c0", cap_q[0], 32'hFFFF_FFF4);

    run_job(2, 0, 2, 'h00, 'h10, 'h20, 1'b0, 0, 0);
    check("k0_done_cycle", done_cyc, 1);

    // Abort on the first write cycle, then a clean rerun
    run_job(2, 2, 2, 'h00, 'h10, 'h20, 1'b0, 4, 0);
    check("abort_no_done", done_cyc, -1);
    run_job(2, 2, 2, 'h00, 'h10, 'h20, 1'b0, 0, 0);
    check("rerun_c0", cap_q[0], 32'd19);
    check("rerun_c3", cap_q[3], 32'd50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gemm_sram_engine.md
Name: gemm_sram_engine

Overview:
Parametrised matrix-multiply engine. It computes C = A x B, or C = A x B^T, with operands read from two single-port-read SRAMs and C written row-major to a result SRAM. Dimensions, base addresses and mode are supplied per job through config ports. This lets one instance serve every projection and score/context product in the self-attention datapath, without the fixed header-driven Q/K/V/S sequencing of the previous engine.

Parameters:
DATA_W, 32, width of SRAM data words and of A/B/C elements
ADDR_W, 16, width of SRAM addresses
DIM_W, 16, width of the M/K/N dimension config fields
SIGNED, 0, 1 = two's-complement multiply/accumulate; 0 = unsigned

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous job cancel
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
cfg_m  in  DIM_W  rows of A and C
cfg_k  in  DIM_W  inner dimension
cfg_n  in  DIM_W  columns of C
cfg_a_base  in  ADDR_W  A base address
cfg_b_base  in  ADDR_W  B base address
cfg_c_base  in  ADDR_W  C base address
cfg_transpose_b  in  1  0: B stored KxN row-major; 1: B stored NxK row-major (use B^T)
a_rd_addr  out  ADDR_W  A SRAM read address
a_rd_data  in  DATA_W  A SRAM read data, valid one cycle after its address
b_rd_addr  out  ADDR_W  B SRAM read address
b_rd_data  in  DATA_W  B SRAM read data, valid one cycle after its address
c_wr_en  out  1  C SRAM write enable
c_wr_addr  out  ADDR_W  C SRAM write address
c_wr_data  out  DATA_W  C SRAM write data

Behaviour:
- Reset: state IDLE. busy=0, done=0, c_wr_en=0; all addresses 0; c_wr_data 0; counters and accumulator 0.
- States:
  - IDLE: start=1 latches all cfg_* and goes to ISSUE. If any of M, K, N is 0, go to DONE instead.
  - ISSUE: one A read and one B read per cycle, loop order i (0..M-1), j (0..N-1), k (0..K-1), k innermost. After the last read (i=M-1, j=N-1, k=K-1), go to DRAIN.
  - DRAIN: 2 cycles, flushing the data and write stages. Then go to DONE.
  - DONE: done=1 for exactly one cycle with busy=0. Next state is IDLE.
- Addresses (all mod 2^ADDR_W):
  - a_rd_addr = a_base + i*K + k
  - b_rd_addr = b_base + k*N + j when transpose_b=0; b_base + j*K + k when transpose_b=1
  - c_wr_addr = c_base + i*N + j
  - Generate addresses incrementally (adders); no per-cycle multiplier is required.
- Pipeline:
  - A read issued in cycle t returns data in cycle t+1. Its product is accumulated at the end of t+1.
  - On k=0 the accumulator loads the product; otherwise it adds the product.
  - For element (i,j), c_wr_en is high in the cycle after its k=K-1 data cycle. Its c_wr_data is the complete sum, registered.
  - Back-to-back elements: no bubbles, one C write every K cycles. K=1 gives one write per cycle.
- Timing: with start accepted at edge 0, the first read address is presented in cycle 1. Reads end in cycle MNK, the last write is in cycle MNK+2, and done is in cycle MNK+3. Each job issues exactly M*N*K reads and M*N writes.
- Arithmetic:
  - Products are full 2*DATA_W wide, signed or unsigned per SIGNED.
  - The accumulator is DATA_W wide and wraps mod 2^DATA_W. There is no saturation.
- Address outputs outside ISSUE hold their last value. c_wr_data is don't-care when c_wr_en=0.
- start while not IDLE is ignored. cfg_* changes after acceptance have no effect on the running job.
- abort=1 in any non-IDLE state:
  - c_wr_en is forced 0 in that same cycle.
  - The next state is IDLE, busy drops the next cycle, and no done pulse is produced.
  - abort in IDLE is ignored. If abort and start are both high in IDLE, start wins.
- reset_n=0 mid-job returns to the reset state on the next edge; no further writes occur.

Test Plan:
- M=K=N=2, transpose_b=0, A=[1,2,3,4] at base 0, B=[5,6,7,8] at base 0x10, c_base=0x20 -> writes 19,22,43,50 to 0x20..0x23; done in cycle 11.
- Same memory contents with transpose_b=1 -> writes 17,23,39,53 to 0x20..0x23.
- M=3, K=1, N=4 (outer product) -> 12 consecutive-cycle writes, each equal to a_i*b_j; done in cycle 15.
- M=1, K=1, N=1: with SIGNED=0, A=0xFFFFFFFF and B=2 -> 0xFFFFFFFE. With SIGNED=1, A=-3 and B=4 -> 0xFFFFFFF4.
- cfg_k=0 -> no reads or writes; done pulse in cycle 1. A second start while busy is ignored: write count stays M*N.
- abort asserted on the cycle the first write would occur in the 2x2x2 job -> no c_wr_en, no done; busy=0 the next cycle. A fresh start then completes normally with 19,22,43,50.
